// File: rtl/alu_exec_unit_if.sv
// rtl/alu_exec_unit_if.sv - issue/writeback handshake bundle for alu_exec_unit
//
// Purpose: groups the op-issue stream, the result stream and the status
// outputs of alu_exec_unit into one interface.
// Signals:
//   in_valid/in_ready   issue handshake (op, a, b qualified by in_valid)
//   op, a, b            opcode and operands
//   out_valid/out_ready writeback handshake (result and flags qualified)
//   result              registered result
//   flag_z/n/c/v/dz     zero, negative, carry, overflow, divide-by-zero
//   busy                divider iterating
// Modports: master = issue/writeback side, slave = execution unit.
interface alu_exec_unit_if #(
  parameter int N = 16
) ();
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   op;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] result;
  logic         flag_z;
  logic         flag_n;
  logic         flag_c;
  logic         flag_v;
  logic         flag_dz;
  logic         busy;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, flag_z, flag_n, flag_c, flag_v,
           flag_dz, busy
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, flag_z, flag_n, flag_c, flag_v,
           flag_dz, busy
  );
endinterface

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - handshaked ALU execution stage with iterative divider
//
// Purpose: accepts one op per input transfer, produces a registered result
// plus status flags under writeback backpressure. DIV/MOD with a nonzero
// divisor run an N-cycle unsigned restoring divider; everything else,
// including divide by zero and illegal ops, completes in one cycle.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    alu_exec_unit_if slave modport (issue, writeback, flags, busy)
module alu_exec_unit #(
  parameter int N = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_exec_unit_if.slave  bus
);

  localparam logic [3:0] OP_SUB  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_MOV  = 4'd3;
  localparam logic [3:0] OP_COMP = 4'd4;
  localparam logic [3:0] OP_DIV  = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_AND  = 4'd7;
  localparam logic [3:0] OP_NOT  = 4'd8;
  localparam logic [3:0] OP_MOD  = 4'd9;

  localparam int CNT_W = $clog2(N);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIV,
    S_OUT
  } state_t;

  state_t           r_state;
  logic [N-1:0]     r_result;
  logic             r_z;
  logic             r_n;
  logic             r_c;
  logic             r_v;
  logic             r_dz;
  logic             r_out_valid;
  logic             r_busy;

  // Divider working set: quotient register starts as the dividend and
  // shifts quotient bits in from the bottom as dividend bits leave the top.
  logic [N-1:0]     r_quo;
  logic [N-1:0]     r_rem;
  logic [N-1:0]     r_dvs;
  logic [CNT_W-1:0] r_cnt;
  logic             r_is_mod;

  logic             w_in_ready;
  logic             w_in_fire;
  logic             w_start_div;

  logic [N:0]       w_sum;
  logic [N-1:0]     w_diff;
  logic [2*N-1:0]   w_prod;
  logic [N-1:0]     w_res;
  logic             w_z;
  logic             w_n;
  logic             w_c;
  logic             w_v;
  logic             w_dz;

  logic [N:0]       w_rem_sh;
  logic             w_ge;
  logic [N:0]       w_rem_sub;
  logic [N-1:0]     w_rem_nxt;
  logic [N-1:0]     w_quo_nxt;
  logic [N-1:0]     w_div_res;

  // In OUT the slot frees in the same cycle the held result drains, which
  // is what allows one result per cycle for back-to-back single-cycle ops.
  assign w_in_ready = rst_n & ((r_state == S_IDLE) |
                               ((r_state == S_OUT) & bus.out_ready));
  assign w_in_fire  = bus.in_valid & w_in_ready;
  assign w_start_div = ((bus.op == OP_DIV) || (bus.op == OP_MOD)) &&
                       (bus.b != '0);

  assign w_sum  = {1'b0, bus.a} + {1'b0, bus.b};
  assign w_diff = bus.a - bus.b;
  assign w_prod = {{N{1'b0}}, bus.a} * {{N{1'b0}}, bus.b};

  // Single-cycle result and flags, evaluated on the presented operands.
  always_comb begin
    w_res = '0;
    w_z   = 1'b0;
    w_n   = 1'b0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    w_dz  = 1'b0;
    case (bus.op)
      OP_SUB, OP_COMP: begin
        w_res = (bus.op == OP_COMP) ? bus.a : w_diff;
        w_z   = (w_diff == '0);
        w_n   = w_diff[N-1];
        w_c   = (bus.a < bus.b);
        w_v   = (bus.a[N-1] != bus.b[N-1]) && (w_diff[N-1] != bus.a[N-1]);
      end
      OP_ADD: begin
        w_res = w_sum[N-1:0];
        w_z   = (w_sum[N-1:0] == '0);
        w_n   = w_sum[N-1];
        w_c   = w_sum[N];
        w_v   = (bus.a[N-1] == bus.b[N-1]) && (w_sum[N-1] != bus.a[N-1]);
      end
      OP_MUL: begin
        w_res = w_prod[N-1:0];
        w_z   = (w_prod[N-1:0] == '0);
        w_n   = w_prod[N-1];
        w_c   = (w_prod[2*N-1:N] != '0);
      end
      OP_MOV, OP_XOR, OP_AND, OP_NOT: begin
        if (bus.op == OP_MOV)      w_res = bus.b;
        else if (bus.op == OP_XOR) w_res = bus.a ^ bus.b;
        else if (bus.op == OP_AND) w_res = bus.a & bus.b;
        else                       w_res = ~bus.a;
        w_z = (w_res == '0);
        w_n = w_res[N-1];
      end
      OP_DIV, OP_MOD: begin
        // Only reached for b == 0 on the single-cycle path.
        w_res = (bus.op == OP_DIV) ? {N{1'b1}} : bus.a;
        w_z   = (w_res == '0);
        w_n   = w_res[N-1];
        w_dz  = 1'b1;
      end
      default: begin
        w_res = '0;
        w_z   = 1'b1;
      end
    endcase
  end

  // One restoring-division step: shift the next dividend bit into the
  // partial remainder and subtract the divisor when it fits.
  assign w_rem_sh  = {r_rem, r_quo[N-1]};
  assign w_ge      = (w_rem_sh >= {1'b0, r_dvs});
  assign w_rem_sub = w_rem_sh - {1'b0, r_dvs};
  assign w_rem_nxt = w_ge ? w_rem_sub[N-1:0] : w_rem_sh[N-1:0];
  assign w_quo_nxt = {r_quo[N-2:0], w_ge};
  assign w_div_res = r_is_mod ? w_rem_nxt : w_quo_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_result    <= '0;
      r_z         <= 1'b0;
      r_n         <= 1'b0;
      r_c         <= 1'b0;
      r_v         <= 1'b0;
      r_dz        <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_quo       <= '0;
      r_rem       <= '0;
      r_dvs       <= '0;
      r_cnt       <= '0;
      r_is_mod    <= 1'b0;
    end else if (r_state == S_DIV) begin
      r_quo <= w_quo_nxt;
      r_rem <= w_rem_nxt;
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == CNT_W'(N - 1)) begin
        r_result    <= w_div_res;
        r_z         <= (w_div_res == '0);
        r_n         <= w_div_res[N-1];
        r_c         <= 1'b0;
        r_v         <= 1'b0;
        r_dz        <= 1'b0;
        r_out_valid <= 1'b1;
        r_busy      <= 1'b0;
        r_state     <= S_OUT;
      end
    end else if (w_in_fire) begin
      if (w_start_div) begin
        r_quo       <= bus.a;
        r_rem       <= '0;
        r_dvs       <= bus.b;
        r_cnt       <= '0;
        r_is_mod    <= (bus.op == OP_MOD);
        r_busy      <= 1'b1;
        r_out_valid <= 1'b0;
        r_state     <= S_DIV;
      end else begin
        r_result    <= w_res;
        r_z         <= w_z;
        r_n         <= w_n;
        r_c         <= w_c;
        r_v         <= w_v;
        r_dz        <= w_dz;
        r_out_valid <= 1'b1;
        r_state     <= S_OUT;
      end
    end else if ((r_state == S_OUT) && bus.out_ready) begin
      r_out_valid <= 1'b0;
      r_state     <= S_IDLE;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
  assign bus.flag_z    = r_z;
  assign bus.flag_n    = r_n;
  assign bus.flag_c    = r_c;
  assign bus.flag_v    = r_v;
  assign bus.flag_dz   = r_dz;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - directed self-checking bench for alu_exec_unit
module tb_alu_exec_unit;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  alu_exec_unit_if #(.N(16)) bus ();

  alu_exec_unit #(.N(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // {z, n, c, v, dz}
  logic [4:0] flags;
  assign flags = {bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v, bus.flag_dz};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op        = 4'd0;
    bus.a         = 16'h0;
    bus.b         = 16'h0;
    bus.out_ready = 1'b1;
    #2;
    tests++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_ctrl: in_ready=%b out_valid=%b busy=%b, want 0 0 0",
               bus.in_ready, bus.out_valid, bus.busy);
    end
    tests++;
    if (bus.result !== 16'h0 || flags !== 5'b0) begin
      fails++;
      $display("FAIL reset_data: result=%h flags=%b, want 0000 00000", bus.result, flags);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests++;
    if (bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_release_ready: in_ready=%b want 1", bus.in_ready);
    end
  endtask

  // Starts and ends at a negedge with the unit idle and in_valid low.
  task automatic test_single(input string name, input logic [3:0] op,
                             input logic [15:0] a, input logic [15:0] b,
                             input logic [15:0] exp_res, input logic [4:0] exp_fl);
    bus.op = op; bus.a = a; bus.b = b; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    #1;
    tests++;
    if (bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL %s_in_ready: got %b want 1", name, bus.in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    tests++;
    if (bus.out_valid !== 1'b1 || bus.result !== exp_res || flags !== exp_fl) begin
      fails++;
      $display("FAIL %s: out_valid=%b result=%h flags=%b want 1 %h %b",
               name, bus.out_valid, bus.result, flags, exp_res, exp_fl);
    end
    @(negedge clk);
    tests++;
    if (bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL %s_drain: out_valid=%b want 0", name, bus.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    bus.op = 4'd0; bus.a = 16'h0003; bus.b = 16'h0005;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tests++;
    if (bus.out_valid !== 1'b1 || bus.result !== 16'hFFFE || flags !== 5'b01100) begin
      fails++;
      $display("FAIL b2b_sub: out_valid=%b result=%h flags=%b want 1 fffe 01100",
               bus.out_valid, bus.result, flags);
    end
    tests++;
    if (bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL b2b_ready: in_ready=%b want 1", bus.in_ready);
    end
    bus.op = 4'd4; bus.a = 16'h1234; bus.b = 16'h1234;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    tests++;
    if (bus.out_valid !== 1'b1 || bus.result !== 16'h1234 || flags !== 5'b10000) begin
      fails++;
      $display("FAIL b2b_comp: out_valid=%b result=%h flags=%b want 1 1234 10000",
               bus.out_valid, bus.result, flags);
    end
    @(negedge clk);
    tests++;
    if (bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL b2b_drain: out_valid=%b want 0", bus.out_valid);
    end
  endtask

  task automatic test_div(input string name, input logic [3:0] op,
                          input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] exp_res, input logic [4:0] exp_fl);
    int bad;
    bus.op = op; bus.a = a; bus.b = b; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    // Scramble inputs: the divider must work on the latched operands.
    bus.in_valid = 1'b0; bus.a = 16'h0000; bus.b = 16'h0001; bus.op = 4'd1;
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk);
      if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL %s_busy: %0d of 16 cycles wrong busy/in_ready/out_valid, want 0",
               name, bad);
    end
    @(negedge clk);
    tests++;
    if (bus.out_valid !== 1'b1 || bus.busy !== 1'b0 || bus.result !== exp_res ||
        flags !== exp_fl) begin
      fails++;
      $display("FAIL %s: out_valid=%b busy=%b result=%h flags=%b want 1 0 %h %b",
               name, bus.out_valid, bus.busy, bus.result, flags, exp_res, exp_fl);
    end
    @(negedge clk);
    tests++;
    if (bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL %s_drain: out_valid=%b want 0", name, bus.out_valid);
    end
  endtask

  task automatic test_backpressure();
    int bad;
    bus.op = 4'd6; bus.a = 16'hA5A5; bus.b = 16'hFFFF;
    bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    // Next op is already presented but must not be taken while stalled.
    bus.op = 4'd1; bus.a = 16'h0002; bus.b = 16'h0003;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      if (bus.out_valid !== 1'b1 || bus.result !== 16'h5A5A || flags !== 5'b0 ||
          bus.in_ready !== 1'b0) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL bp_hold: %0d of 3 stalled cycles wrong, result=%h want 5a5a",
               bad, bus.result);
    end
    bus.out_ready = 1'b1;
    #1;
    tests++;
    if (bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_release_ready: in_ready=%b want 1", bus.in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    tests++;
    if (bus.out_valid !== 1'b1 || bus.result !== 16'h0005 || flags !== 5'b0) begin
      fails++;
      $display("FAIL bp_next_add: out_valid=%b result=%h flags=%b want 1 0005 00000",
               bus.out_valid, bus.result, flags);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_div();
    bus.op = 4'd5; bus.a = 16'd100; bus.b = 16'd7;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    tests++;
    if (bus.busy !== 1'b1) begin
      fails++;
      $display("FAIL rst_div_busy: busy=%b want 1", bus.busy);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 ||
        bus.result !== 16'h0 || flags !== 5'b0) begin
      fails++;
      $display("FAIL rst_div_clear: busy=%b out_valid=%b in_ready=%b result=%h flags=%b want all 0",
               bus.busy, bus.out_valid, bus.in_ready, bus.result, flags);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests++;
    if (bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL rst_div_idle: in_ready=%b want 1", bus.in_ready);
    end
    repeat (17) @(negedge clk);
    tests++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL rst_div_stale: out_valid=%b busy=%b want 0 0", bus.out_valid, bus.busy);
    end
    test_single("rst_add", 4'd1, 16'h0001, 16'h0001, 16'h0002, 5'b00000);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    @(negedge clk);
    test_single("add_ovf", 4'd1, 16'h7FFF, 16'h0001, 16'h8000, 5'b01010);
    test_back_to_back();
    test_single("mul_ovf", 4'd2, 16'h0100, 16'h0100, 16'h0000, 5'b10100);
    test_single("mov", 4'd3, 16'h1111, 16'h8001, 16'h8001, 5'b01000);
    test_single("and", 4'd7, 16'hF0F0, 16'h0FF0, 16'h00F0, 5'b00000);
    test_single("not", 4'd8, 16'hFFFF, 16'h1234, 16'h0000, 5'b10000);
    test_single("sub_v", 4'd0, 16'h8000, 16'h0001, 16'h7FFF, 5'b00010);
    test_single("add_c", 4'd1, 16'hFFFF, 16'h0001, 16'h0000, 5'b10100);
    test_div("div_100_7", 4'd5, 16'd100, 16'd7, 16'h000E, 5'b00000);
    test_div("mod_100_7", 4'd9, 16'd100, 16'd7, 16'h0002, 5'b00000);
    test_div("div_ffff_1", 4'd5, 16'hFFFF, 16'h0001, 16'hFFFF, 5'b01000);
    test_single("div_zero", 4'd5, 16'h1234, 16'h0000, 16'hFFFF, 5'b01001);
    test_single("mod_zero", 4'd9, 16'h1234, 16'h0000, 16'h1234, 5'b00001);
    test_single("illegal", 4'd12, 16'h5555, 16'h3333, 16'h0000, 5'b10000);
    test_backpressure();
    test_reset_mid_div();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
Parametrised successor to the core's ALU result-select stage. Holds the same 10-op encoding, plus the following:
- registered, handshaked result path;
- status flags;
- a multi-cycle iterative divider for DIV/MOD.
Sits between decode/issue and writeback. Issue pushes one op per transfer and writeback drains results under backpressure.

Parameters:
N, 16, data width in bits (N >= 4)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  issue presents an op
in_ready  output  1  unit accepts an op this cycle
op  input  4  0 SUB, 1 ADD, 2 MUL, 3 MOV, 4 COMP, 5 DIV, 6 XOR, 7 AND, 8 NOT, 9 MOD, 10-15 illegal
a  input  N  operand A
b  input  N  operand B
out_valid  output  1  result and flags valid
out_ready  input  1  writeback accepts result
result  output  N  registered result
flag_z  output  1  zero
flag_n  output  1  negative (MSB)
flag_c  output  1  carry/borrow/mul-overflow
flag_v  output  1  signed overflow
flag_dz  output  1  divide by zero
busy  output  1  divider iterating

Behaviour:
- Reset (rst_n low, async):
  - state=IDLE.
  - result, all flags, out_valid and busy are 0.
  - Divider registers are cleared.
  - in_ready=0 while rst_n is low.
- Reset mid-operation: an in-flight division or held result is discarded and no output is produced.
- Transfer rules:
  - Input transfer = in_valid & in_ready, sampled at the rising edge.
  - Output transfer = out_valid & out_ready.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - DIV: in_ready=0, busy=1, out_valid=0.
  - OUT: out_valid=1; in_ready = out_ready.
- Transitions:
  - Accept of a single-cycle op (any op except DIV/MOD with b!=0): result/flags registered at that edge; next state OUT. Latency 1.
  - Accept of DIV/MOD with b!=0: latch a and b; next state DIV.
  - DIV: unsigned restoring divider, one quotient bit per cycle, N cycles. On the N-th iteration edge, load result and go to OUT. out_valid rises N+1 cycles after accept.
  - OUT with output transfer and no input transfer: go to IDLE.
  - OUT with output transfer and a simultaneous input transfer: behave as an accept from IDLE. A single-cycle op keeps out_valid=1, giving 1 result/cycle.
  - OUT without out_ready: result and flags hold stable; in_ready=0.
- Op semantics (all arithmetic modulo 2^N):
  - SUB: a-b.
  - ADD: a+b.
  - MUL: low N bits of a*b.
  - MOV: b.
  - COMP: result=a, flags computed from a-b.
  - DIV: unsigned quotient.
  - XOR: a^b.
  - AND: a&b.
  - NOT: ~a.
  - MOD: unsigned remainder.
- Flags:
  - flag_z: result==0; for COMP, (a-b)==0.
  - flag_n: result[N-1]; for COMP, (a-b)[N-1].
  - flag_c:
    - ADD: carry-out.
    - SUB/COMP: borrow (a<b unsigned).
    - MUL: high N bits nonzero.
    - All other ops: 0.
  - flag_v: signed overflow for ADD/SUB/COMP, else 0.
  - flag_dz: 1 only for DIV/MOD with b==0.
- Divide by zero is single-cycle (latency 1, no DIV state):
  - DIV: result=all ones.
  - MOD: result=a.
  - flag_dz=1.
- Illegal op (10-15): accepted; result=0, flag_z=1, other flags 0, latency 1.
- Operands and op are sampled only at accept. Changes on a/b/op afterwards have no effect.

Test Plan:
- ADD 0x7FFF+0x0001, out_ready=1 -> one cycle after accept: result 0x8000, n=1, v=1, c=0, z=0; next cycle out_valid=0.
- SUB 0x0003-0x0005 then COMP 0x1234,0x1234 back-to-back -> cycle1: result 0xFFFE, c=1, n=1. Cycle2: result 0x1234, z=1, c=0. out_valid stays high with no bubble.
- MUL 0x0100*0x0100 -> result 0x0000, z=1, c=1.
- DIV 100/7 -> in_ready=0 and busy=1 for 16 cycles; out_valid 17 cycles after accept, result 0x000E. MOD 100/7 -> 0x0002. DIV 0xFFFF/0x0001 -> 0xFFFF.
- DIV 0x1234/0 -> latency 1, result 0xFFFF, dz=1. MOD 0x1234/0 -> 0x1234, dz=1. Op 12 -> result 0, z=1.
- Backpressure and reset:
  - XOR result held with out_ready=0 for 3 cycles: result and flags stable, in_ready=0. Then out_ready=1 with ADD 2+3 presented -> next result 0x0005.
  - rst_n pulsed low on the 5th DIV cycle -> outputs 0 immediately. After release: IDLE, in_ready=1, no stale result; a following ADD 1+1 returns 0x0002.
